// File: rtl/nibble_pkg.sv
// -----------------------------------------------------------------------------
// nibble_pkg
// Shared definitions for the nibble datapath scheduler (nibble_ctrl).
//   - Command word layout (92 bits):
//     {SEL_AB[3:0], SEL_B[11:0], SEL_A[11:0], DATA_B[31:0], DATA_A[31:0]}
//   - Default datapath latency, requester-ID width, perf counter width.
// No ports (package).
// -----------------------------------------------------------------------------
package nibble_pkg;

    localparam int DATA_W   = 32;
    localparam int SEL_W    = 12;
    localparam int SELAB_W  = 4;
    localparam int NIB_W    = 4;
    localparam int CMD_W    = SELAB_W + 2 * SEL_W + 2 * DATA_W;   // 92

    // Field offsets inside the command word
    localparam int DATA_A_LSB = 0;
    localparam int DATA_B_LSB = DATA_A_LSB + DATA_W;             // 32
    localparam int SEL_A_LSB  = DATA_B_LSB + DATA_W;             // 64
    localparam int SEL_B_LSB  = SEL_A_LSB + SEL_W;               // 76
    localparam int SEL_AB_LSB = SEL_B_LSB + SEL_W;               // 88

    localparam int LAT_DEF  = 3;
    localparam int ID_W     = 1;
    localparam int PERF_W   = 16;

    // Packed view of the command word; member order matches the bit layout.
    typedef struct packed {
        logic [SELAB_W-1:0] sel_ab;
        logic [SEL_W-1:0]   sel_b;
        logic [SEL_W-1:0]   sel_a;
        logic [DATA_W-1:0]  data_b;
        logic [DATA_W-1:0]  data_a;
    } cmd_t;

endpackage

// File: rtl/nibble_ctrl_if.sv
// -----------------------------------------------------------------------------
// nibble_ctrl_if
// Command/response bundle between the two command masters and nibble_ctrl.
//   REQ[1:0]        per-requester request (master -> ctrl)
//   GNT[1:0]        one-hot-or-zero grant (ctrl -> master, combinational)
//   CMD0, CMD1      92-bit commands (master -> ctrl)
//   RSP_VALID       one-cycle result strobe (ctrl -> master)
//   RSP_ID          requester that owns the result
//   RSP_NIBBLE      captured datapath result
// Modports: master (command side), slave (nibble_ctrl side).
// -----------------------------------------------------------------------------
interface nibble_ctrl_if;
    import nibble_pkg::*;

    logic [1:0]       REQ;
    logic [1:0]       GNT;
    logic [CMD_W-1:0] CMD0;
    logic [CMD_W-1:0] CMD1;
    logic             RSP_VALID;
    logic [ID_W-1:0]  RSP_ID;
    logic [NIB_W-1:0] RSP_NIBBLE;

    modport master (
        output REQ, CMD0, CMD1,
        input  GNT, RSP_VALID, RSP_ID, RSP_NIBBLE
    );

    modport slave (
        input  REQ, CMD0, CMD1,
        output GNT, RSP_VALID, RSP_ID, RSP_NIBBLE
    );

endinterface

// File: rtl/nibble_ctrl_rr_arb.sv
// -----------------------------------------------------------------------------
// nibble_ctrl_rr_arb
// Two-way round-robin arbiter. Grant is combinational from the requests,
// the enable and the priority pointer; the pointer moves to the losing
// requester on every transfer and holds otherwise.
// Ports:
//   CLK, RESET     clock, synchronous active-high reset (pointer -> 0)
//   i_req[1:0]     requests
//   i_enable       0 blocks all grants
//   o_gnt[1:0]     one-hot-or-zero grant
//   i_xfer         a transfer happens at this edge
//   i_xfer_id      requester that transferred
// -----------------------------------------------------------------------------
module nibble_ctrl_rr_arb
    import nibble_pkg::*;
(
    input  logic            CLK,
    input  logic            RESET,
    input  logic [1:0]      i_req,
    input  logic            i_enable,
    output logic [1:0]      o_gnt,
    input  logic            i_xfer,
    input  logic [ID_W-1:0] i_xfer_id
);

    logic r_ptr;

    always_comb begin
        o_gnt = 2'b00;
        if (i_enable) begin
            case (i_req)
                2'b01:   o_gnt = 2'b01;
                2'b10:   o_gnt = 2'b10;
                2'b11:   o_gnt = r_ptr ? 2'b10 : 2'b01;
                default: o_gnt = 2'b00;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_ptr <= 1'b0;
        end else if (i_xfer) begin
            r_ptr <= ~i_xfer_id[0];
        end
    end

endmodule

// File: rtl/nibble_ctrl.sv
// -----------------------------------------------------------------------------
// nibble_ctrl
// Two-requester scheduler for the nibble datapath. Arbitrates round-robin,
// registers the granted command onto the datapath inputs, tracks each issue
// through the datapath latency and returns the result tagged with its ID.
// Ports:
//   CLK, RESET         clock, synchronous active-high reset
//   ENABLE             0 blocks new grants; in-flight work still drains
//   bus (slave)        REQ/GNT/CMD0/CMD1/RSP_VALID/RSP_ID/RSP_NIBBLE
//   NB_DATA_A/B        32-bit datapath operands
//   NB_SEL_A/B         12-bit datapath selectors
//   NB_SEL_AB          4-bit datapath selector
//   NB_DATA_OUT        4-bit datapath result
//   BUSY               any operation in flight
//   PERF_CNT0/1        16-bit saturating transfer counters, only present
//                      when NIBBLE_CTRL_PERF_EN is defined
// Parameter LAT (>= 1): edges from an NB_* update to a valid NB_DATA_OUT.
// -----------------------------------------------------------------------------
module nibble_ctrl
    import nibble_pkg::*;
#(
    parameter int LAT = LAT_DEF
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               ENABLE,
    nibble_ctrl_if.slave       bus,
    output logic [DATA_W-1:0]  NB_DATA_A,
    output logic [DATA_W-1:0]  NB_DATA_B,
    output logic [SEL_W-1:0]   NB_SEL_A,
    output logic [SEL_W-1:0]   NB_SEL_B,
    output logic [SELAB_W-1:0] NB_SEL_AB,
    input  logic [NIB_W-1:0]   NB_DATA_OUT,
    output logic               BUSY
`ifdef NIBBLE_CTRL_PERF_EN
    ,
    output logic [PERF_W-1:0]  PERF_CNT0,
    output logic [PERF_W-1:0]  PERF_CNT1
`endif
);

    logic [1:0]      w_gnt;
    logic            w_xfer;
    logic [ID_W-1:0] w_gnt_id;
    cmd_t            w_cmd;

    nibble_ctrl_rr_arb u_arb (
        .CLK       (CLK),
        .RESET     (RESET),
        .i_req     (bus.REQ),
        .i_enable  (ENABLE),
        .o_gnt     (w_gnt),
        .i_xfer    (w_xfer),
        .i_xfer_id (w_gnt_id)
    );

    assign bus.GNT  = w_gnt;
    assign w_xfer   = |(bus.REQ & w_gnt);
    assign w_gnt_id = w_gnt[1];
    assign w_cmd    = w_gnt[1] ? bus.CMD1 : bus.CMD0;

    // ---- stage: datapath input registers (load on transfer, else hold) ----
    logic [DATA_W-1:0]  r_nb_data_a;
    logic [DATA_W-1:0]  r_nb_data_b;
    logic [SEL_W-1:0]   r_nb_sel_a;
    logic [SEL_W-1:0]   r_nb_sel_b;
    logic [SELAB_W-1:0] r_nb_sel_ab;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_nb_data_a <= '0;
            r_nb_data_b <= '0;
            r_nb_sel_a  <= '0;
            r_nb_sel_b  <= '0;
            r_nb_sel_ab <= '0;
        end else if (w_xfer) begin
            r_nb_data_a <= w_cmd.data_a;
            r_nb_data_b <= w_cmd.data_b;
            r_nb_sel_a  <= w_cmd.sel_a;
            r_nb_sel_b  <= w_cmd.sel_b;
            r_nb_sel_ab <= w_cmd.sel_ab;
        end
    end

    assign NB_DATA_A = r_nb_data_a;
    assign NB_DATA_B = r_nb_data_b;
    assign NB_SEL_A  = r_nb_sel_a;
    assign NB_SEL_B  = r_nb_sel_b;
    assign NB_SEL_AB = r_nb_sel_ab;

    // ---- stage: tracking pipe, LAT+1 entries of {valid, id} ----
    // Entry 0 is written at the transfer edge, so entry LAT is valid in the
    // cycle where NB_DATA_OUT carries that operation's result.
    logic [LAT:0]    r_pipe_vld;
    logic [ID_W-1:0] r_pipe_id [0:LAT];

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_pipe_vld <= '0;
            for (int i = 0; i <= LAT; i++) begin
                r_pipe_id[i] <= '0;
            end
        end else begin
            r_pipe_vld   <= {r_pipe_vld[LAT-1:0], w_xfer};
            r_pipe_id[0] <= w_gnt_id;
            for (int i = 1; i <= LAT; i++) begin
                r_pipe_id[i] <= r_pipe_id[i-1];
            end
        end
    end

    // ---- stage: response registers ----
    // The result is captured at the same edge that raises RSP_VALID, so
    // RSP_NIBBLE is always aligned with its strobe and ID.
    logic             r_rsp_valid;
    logic [ID_W-1:0]  r_rsp_id;
    logic [NIB_W-1:0] r_rsp_nibble;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= '0;
            r_rsp_nibble <= '0;
        end else begin
            r_rsp_valid <= r_pipe_vld[LAT];
            if (r_pipe_vld[LAT]) begin
                r_rsp_id     <= r_pipe_id[LAT];
                r_rsp_nibble <= NB_DATA_OUT;
            end
        end
    end

    assign bus.RSP_VALID  = r_rsp_valid;
    assign bus.RSP_ID     = r_rsp_id;
    assign bus.RSP_NIBBLE = r_rsp_nibble;

    // The response register counts as the final tracking entry, so BUSY stays
    // high through the RSP_VALID cycle.
    assign BUSY = (|r_pipe_vld) | r_rsp_valid;

`ifdef NIBBLE_CTRL_PERF_EN
    // ---- stage: per-requester transfer counters ----
    logic [PERF_W-1:0] r_perf_cnt0;
    logic [PERF_W-1:0] r_perf_cnt1;

    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
        return (v == {PERF_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_perf_cnt0 <= '0;
            r_perf_cnt1 <= '0;
        end else if (w_xfer) begin
            if (w_gnt_id == 1'b0) begin
                r_perf_cnt0 <= sat_inc(r_perf_cnt0);
            end else begin
                r_perf_cnt1 <= sat_inc(r_perf_cnt1);
            end
        end
    end

    assign PERF_CNT0 = r_perf_cnt0;
    assign PERF_CNT1 = r_perf_cnt1;
`endif

endmodule

// File: tb/tb_nibble_ctrl.sv
// -----------------------------------------------------------------------------
// tb_nibble_ctrl
// Directed bench for nibble_ctrl with LAT = 3. A stand-in datapath returns
// nibble SEL_A[2:0] of DATA_A after LAT register stages. Perf counter checks
// are compiled in when NIBBLE_CTRL_PERF_EN is defined.
// -----------------------------------------------------------------------------
module tb_nibble_ctrl;
    import nibble_pkg::*;

    localparam int LAT = 3;

    logic               CLK;
    logic               RESET;
    logic               ENABLE;
    logic [DATA_W-1:0]  NB_DATA_A;
    logic [DATA_W-1:0]  NB_DATA_B;
    logic [SEL_W-1:0]   NB_SEL_A;
    logic [SEL_W-1:0]   NB_SEL_B;
    logic [SELAB_W-1:0] NB_SEL_AB;
    logic [NIB_W-1:0]   NB_DATA_OUT;
    logic               BUSY;
`ifdef NIBBLE_CTRL_PERF_EN
    logic [PERF_W-1:0]  PERF_CNT0;
    logic [PERF_W-1:0]  PERF_CNT1;
`endif

    nibble_ctrl_if bus ();

    nibble_ctrl #(.LAT(LAT)) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .ENABLE      (ENABLE),
        .bus         (bus),
        .NB_DATA_A   (NB_DATA_A),
        .NB_DATA_B   (NB_DATA_B),
        .NB_SEL_A    (NB_SEL_A),
        .NB_SEL_B    (NB_SEL_B),
        .NB_SEL_AB   (NB_SEL_AB),
        .NB_DATA_OUT (NB_DATA_OUT),
        .BUSY        (BUSY)
`ifdef NIBBLE_CTRL_PERF_EN
        ,
        .PERF_CNT0   (PERF_CNT0),
        .PERF_CNT1   (PERF_CNT1)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Stand-in datapath
    logic [NIB_W-1:0] r_dp [0:LAT-1];
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < LAT; i++) r_dp[i] <= '0;
        end else begin
            r_dp[0] <= NB_DATA_A[{NB_SEL_A[2:0], 2'b00} +: 4];
            for (int i = 1; i < LAT; i++) r_dp[i] <= r_dp[i-1];
        end
    end
    assign NB_DATA_OUT = r_dp[LAT-1];

    int checks = 0;
    int errors = 0;

    // Protocol monitor: a requester left ungranted must keep REQ high.
    logic [1:0] pend = 2'b00;
    always @(posedge CLK) begin
        if (!RESET && (|(pend & ~bus.REQ))) begin
            errors++;
            $display("FAIL protocol: REQ=%b while ungranted pending=%b (required REQ held)", bus.REQ, pend);
        end
        pend <= RESET ? 2'b00 : (bus.REQ & ~bus.GNT);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [CMD_W-1:0] mkcmd(input logic [3:0] ab, input logic [11:0] sb,
                                               input logic [11:0] sa, input logic [31:0] db,
                                               input logic [31:0] da);
        return {ab, sb, sa, db, da};
    endfunction

    initial begin
        RESET    = 1'b1;
        ENABLE   = 1'b0;
        bus.REQ  = 2'b00;
        bus.CMD0 = '0;
        bus.CMD1 = '0;
        tick();
        tick();

        // Reset state
        chk("rst_rsp_valid", 32'(bus.RSP_VALID), 32'h0);
        chk("rst_rsp_id", 32'(bus.RSP_ID), 32'h0);
        chk("rst_rsp_nibble", 32'(bus.RSP_NIBBLE), 32'h0);
        chk("rst_busy", 32'(BUSY), 32'h0);
        chk("rst_nb_data_a", NB_DATA_A, 32'h0);
        chk("rst_nb_sel_ab", 32'(NB_SEL_AB), 32'h0);
        chk("rst_gnt", 32'(bus.GNT), 32'h0);
        RESET = 1'b0;

        // Single requester-0 transfer, nibble 0 of 0x12345678 = 0x8
        ENABLE   = 1'b1;
        bus.CMD0 = mkcmd(4'h0, 12'h000, 12'h000, 32'h0, 32'h1234_5678);
        bus.REQ  = 2'b01;
        #1;
        chk("t1_gnt", 32'(bus.GNT), 32'h1);
        tick();
        bus.REQ = 2'b00;
        chk("t1_nb_data_a", NB_DATA_A, 32'h1234_5678);
        chk("t1_busy", 32'(BUSY), 32'h1);
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk("t1_rsp_early", 32'(bus.RSP_VALID), 32'h0);
        end
        tick();
        chk("t1_rsp_valid", 32'(bus.RSP_VALID), 32'h1);
        chk("t1_rsp_id", 32'(bus.RSP_ID), 32'h0);
        chk("t1_rsp_nibble", 32'(bus.RSP_NIBBLE), 32'h8);
        tick();
        chk("t1_rsp_after", 32'(bus.RSP_VALID), 32'h0);
        chk("t1_busy_after", 32'(BUSY), 32'h0);

        // Idle gap: requester-1 transfer, then 6 idle cycles (nibble 5 = 0xB)
        bus.CMD1 = mkcmd(4'hA, 12'h123, 12'h005, 32'hCAFE_F00D, 32'h9ABC_DEF0);
        bus.REQ  = 2'b10;
        #1;
        chk("gap_gnt", 32'(bus.GNT), 32'h2);
        tick();
        bus.REQ  = 2'b00;
        bus.CMD1 = mkcmd(4'h5, 12'h777, 12'h001, 32'h0, 32'h0);
        chk("gap_nb_data_b", NB_DATA_B, 32'hCAFE_F00D);
        chk("gap_nb_sel_a", 32'(NB_SEL_A), 32'h005);
        chk("gap_nb_sel_b", 32'(NB_SEL_B), 32'h123);
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk("gap_rsp_valid", 32'(bus.RSP_VALID), (k == 4) ? 32'h1 : 32'h0);
            chk("gap_busy", 32'(BUSY), (k <= 4) ? 32'h1 : 32'h0);
            chk("gap_nb_data_a_hold", NB_DATA_A, 32'h9ABC_DEF0);
            chk("gap_nb_sel_ab_hold", 32'(NB_SEL_AB), 32'hA);
            if (k == 4) begin
                chk("gap_rsp_id", 32'(bus.RSP_ID), 32'h1);
                chk("gap_rsp_nibble", 32'(bus.RSP_NIBBLE), 32'hB);
            end
        end

        // Both requesting: grants 0,1,0,1 (req0 nibble 1 = 0xA, req1 nibble 2 = 0xC)
        bus.CMD0 = mkcmd(4'h0, 12'h000, 12'h001, 32'h0, 32'h0000_00A0);
        bus.CMD1 = mkcmd(4'h0, 12'h000, 12'h002, 32'h0, 32'h0000_0C00);
        bus.REQ  = 2'b11;
        #1;
        chk("rr_gnt0", 32'(bus.GNT), 32'h1);
        tick();
        chk("rr_gnt1", 32'(bus.GNT), 32'h2);
        tick();
        chk("rr_gnt2", 32'(bus.GNT), 32'h1);
        tick();
        bus.REQ = 2'b10;
        #1;
        chk("rr_gnt3", 32'(bus.GNT), 32'h2);
        tick();
        bus.REQ = 2'b00;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("rr_rsp_valid", 32'(bus.RSP_VALID), 32'h1);
            chk("rr_rsp_id", 32'(bus.RSP_ID), 32'(k % 2));
            chk("rr_rsp_nibble", 32'(bus.RSP_NIBBLE), (k % 2 == 1) ? 32'hC : 32'hA);
        end
        tick();
        chk("rr_rsp_end", 32'(bus.RSP_VALID), 32'h0);
        chk("rr_busy_end", 32'(BUSY), 32'h0);

        // ENABLE low with both requesting: no grants, pointer unchanged
        ENABLE  = 1'b0;
        bus.REQ = 2'b11;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("dis_gnt", 32'(bus.GNT), 32'h0);
            tick();
            chk("dis_busy", 32'(BUSY), 32'h0);
        end
        ENABLE = 1'b1;
        #1;
        chk("en_gnt_first", 32'(bus.GNT), 32'h1);
        tick();
        bus.REQ = 2'b10;
        #1;
        chk("en_gnt_second", 32'(bus.GNT), 32'h2);
        tick();
        bus.REQ = 2'b00;
        tick();
        tick();
        tick();
        chk("en_rsp0_valid", 32'(bus.RSP_VALID), 32'h1);
        chk("en_rsp0_id", 32'(bus.RSP_ID), 32'h0);
        tick();
        chk("en_rsp1_valid", 32'(bus.RSP_VALID), 32'h1);
        chk("en_rsp1_id", 32'(bus.RSP_ID), 32'h1);
        chk("en_rsp1_nibble", 32'(bus.RSP_NIBBLE), 32'hC);
        tick();

        // Reset mid-flight after three back-to-back requester-0 transfers
        bus.CMD0 = mkcmd(4'h3, 12'h0AB, 12'h007, 32'h1111_2222, 32'hF000_0000);
        bus.REQ  = 2'b01;
        tick();
        tick();
        tick();
        bus.REQ = 2'b00;
        tick();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        chk("mid_rst_busy", 32'(BUSY), 32'h0);
        chk("mid_rst_rsp_valid", 32'(bus.RSP_VALID), 32'h0);
        chk("mid_rst_rsp_id", 32'(bus.RSP_ID), 32'h0);
        chk("mid_rst_rsp_nibble", 32'(bus.RSP_NIBBLE), 32'h0);
        chk("mid_rst_nb_data_a", NB_DATA_A, 32'h0);
        chk("mid_rst_nb_data_b", NB_DATA_B, 32'h0);
        chk("mid_rst_nb_sel_a", 32'(NB_SEL_A), 32'h0);
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("mid_rst_no_rsp", 32'(bus.RSP_VALID), 32'h0);
        end
        // Pointer was 1 before reset; reset returns it to 0
        bus.REQ = 2'b11;
        #1;
        chk("mid_rst_ptr", 32'(bus.GNT), 32'h1);
        tick();
        bus.REQ = 2'b10;
        tick();
        bus.REQ = 2'b00;
        for (int k = 0; k < 6; k++) tick();

`ifdef NIBBLE_CTRL_PERF_EN
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        chk("perf_rst_cnt0", 32'(PERF_CNT0), 32'h0);
        chk("perf_rst_cnt1", 32'(PERF_CNT1), 32'h0);
        bus.REQ = 2'b01;
        for (int k = 0; k < 70000; k++) tick();
        bus.REQ = 2'b00;
        tick();
        chk("perf_sat_cnt0", 32'(PERF_CNT0), 32'hFFFF);
        chk("perf_cnt1", 32'(PERF_CNT1), 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
